auth_code_ctrl: RTL

Sequencing controller for the UART byte reader in the security-system datapath. On each entry request it starts the reader with a one-cycle start pulse and collects the code bytes the reader delivers. It then compares the assembled code against a reference code and reports grant or deny. It also tracks consecutive failures and, when compiled in, enforces a timed lockout.

---
 rtl/auth_code_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/auth_code_ctrl.sv
// rtl/auth_code_ctrl.sv - entry-code sequencing controller (timed lockout built when AUTH_LOCKOUT_EN is defined)
module auth_code_ctrl #(
  parameter int NBYTES      = 4,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           arm,
  input  logic                           abort,
  output logic                           rd_start,
  input  logic                           rd_valid,
  input  logic [7:0]                     rd_byte,
  input  logic                           rd_done,
  input  logic [8*NBYTES-1:0]            ref_code,
  output logic                           busy,
  output logic                           granted,
  output logic                           denied,
  output logic                           locked,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

  localparam int CW = 8 * NBYTES;
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int BW = $clog2(NBYTES + 1);
  localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_FAILS);
  localparam logic [BW-1:0] BYTES_FULL = BW'(NBYTES);

  // Reject configurations that would make the counters meaningless
  if (NBYTES < 1 || MAX_FAILS < 1 || LOCK_CYCLES < 1) begin : g_param_check
    $error("auth_code_ctrl: NBYTES, MAX_FAILS and LOCK_CYCLES must all be >= 1");
  end

`ifdef AUTH_LOCKOUT_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_COLLECT, S_CHECK, S_LOCKOUT} state_t;
  localparam int TW = $clog2(LOCK_CYCLES + 1);
  logic [TW-1:0] timer;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_COLLECT, S_CHECK} state_t;
  assign locked = 1'b0;
`endif

  state_t        state;
  logic [CW-1:0] shreg;
  logic [BW-1:0] byte_cnt;
  logic [FW-1:0] fail_inc;
  logic          code_match;

  assign fail_inc   = fail_count + FW'(1);
  assign code_match = (byte_cnt == BYTES_FULL) && (shreg == ref_code);

  // Attempt sequencer: every output is produced here as a register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      rd_start   <= 1'b0;
      busy       <= 1'b0;
      granted    <= 1'b0;
      denied     <= 1'b0;
      fail_count <= '0;
      shreg      <= '0;
      byte_cnt   <= '0;
`ifdef AUTH_LOCKOUT_EN
      locked     <= 1'b0;
      timer      <= '0;
`endif
    end else begin
      rd_start <= 1'b0;
      granted  <= 1'b0;
      denied   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (arm) state <= S_START;
        end
        S_START: begin
          rd_start <= 1'b1;
          busy     <= 1'b1;
          shreg    <= '0;
          byte_cnt <= '0;
          state    <= S_COLLECT;
        end
        S_COLLECT: begin
          if (abort) begin
            // Cancelled attempt: no verdict and the failure history is kept
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            // Bytes beyond the code length are dropped so an over-long entry
            // cannot push the real code out of the register
            if (rd_valid && (byte_cnt != BYTES_FULL)) begin
              shreg    <= (shreg << 8) | CW'(rd_byte);
              byte_cnt <= byte_cnt + BW'(1);
            end
            if (rd_done) state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (code_match) begin
            granted    <= 1'b1;
            fail_count <= '0;
            state      <= S_IDLE;
            busy       <= 1'b0;
          end else begin
            denied <= 1'b1;
`ifdef AUTH_LOCKOUT_EN
            fail_count <= fail_inc;
            if (fail_inc == FAIL_MAX) begin
              state  <= S_LOCKOUT;
              locked <= 1'b1;
              timer  <= TW'(LOCK_CYCLES);
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
`else
            if (fail_count != FAIL_MAX) fail_count <= fail_inc;
            state <= S_IDLE;
            busy  <= 1'b0;
`endif
          end
        end
`ifdef AUTH_LOCKOUT_EN
        S_LOCKOUT: begin
          // Exiting on the cycle the timer would hit zero keeps locked high
          // for exactly LOCK_CYCLES cycles
          if (timer <= TW'(1)) begin
            timer      <= '0;
            locked     <= 1'b0;
            busy       <= 1'b0;
            fail_count <= '0;
            state      <= S_IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
`endif
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
